// File: rtl/logic_result_fifo_if.sv
// logic_result_fifo_if: valid/ready bundle between logic_operations, the result FIFO and writeback.
interface logic_result_fifo_if #(parameter int N = 16);
    logic [N-1:0] in_result;
    logic [2:0]   in_opcode;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] out_data;
    logic         out_zero;
    logic         out_parity;
    logic         out_err;
    logic         out_valid;
    logic         out_ready;
    modport master (output in_result, in_opcode, in_valid, out_ready,
                    input in_ready, out_data, out_zero, out_parity, out_err, out_valid);
    modport slave (input in_result, in_opcode, in_valid, out_ready,
                   output in_ready, out_data, out_zero, out_parity, out_err, out_valid);
endinterface

// File: rtl/logic_result_fifo.sv
// logic_result_fifo: flag-tagging result FIFO ahead of writeback.
// LOGIC_FIFO_ERR_COUNT_EN adds a saturating illegal-opcode counter on err_count.
module logic_result_fifo #(
    parameter int N     = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic               clk,
    input  logic               rst,
    logic_result_fifo_if.slave bus,
    output logic [AW:0]        count,
    output logic [7:0]         err_count
);
    localparam logic [AW:0] full_cnt = (AW+1)'(DEPTH);
    logic [N+2:0]  mem [DEPTH];
    logic [N+2:0]  last, head, entry;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, err;
    // Once empty, the outputs keep showing the last popped entry
    always_comb begin
        err = !(bus.in_opcode inside {3'b000, 3'b001, 3'b010, 3'b100});
        entry = {err, ^bus.in_result, ~|bus.in_result, bus.in_result};
        bus.in_ready = count != full_cnt;
        bus.out_valid = count != '0;
        push = bus.in_valid & bus.in_ready;
        pop = bus.out_valid & bus.out_ready;
        head = bus.out_valid ? mem[rd_ptr] : last;
        {bus.out_err, bus.out_parity, bus.out_zero, bus.out_data} = head;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last   <= mem[rd_ptr];
            end
            if (push & ~pop) count <= count + 1'b1;
            else if (pop & ~push) count <= count - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end
`ifdef LOGIC_FIFO_ERR_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_count <= '0;
        else if (push & err & ~&err_count) err_count <= err_count + 1'b1;
    end
`else
    assign err_count = 8'h00;
`endif
endmodule

// File: tb/tb_logic_result_fifo.sv
// tb_logic_result_fifo: directed checks of reset, ordering, full/empty edges, streaming and error flags.
module tb_logic_result_fifo;
    logic clk = 0;
    logic rst = 1;
    logic [2:0] count;
    logic [7:0] err_count;
    int passed = 0;
    int total = 0;
    logic_result_fifo_if #(.N(16)) bus ();
    logic_result_fifo #(.N(16), .DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst), .bus(bus), .count(count), .err_count(err_count)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic [2:0] op);
        bus.in_result = d;
        bus.in_opcode = op;
        bus.in_valid = 1;
        tick();
        bus.in_valid = 0;
    endtask

    task automatic pop();
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
    endtask

    logic [15:0] exp_d [5];
    logic        exp_p [5];
    logic [7:0]  exp_err2, exp_sat;

    initial begin
`ifdef LOGIC_FIFO_ERR_COUNT_EN
        exp_err2 = 8'd2;
        exp_sat  = 8'hFF;
`else
        exp_err2 = 8'd0;
        exp_sat  = 8'd0;
`endif
        bus.in_result = '0;
        bus.in_opcode = '0;
        bus.in_valid = 0;
        bus.out_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_err_count", 32'(err_count), 0);

        push(16'h0000, 3'b000);
        chk("empty_push_valid", 32'(bus.out_valid), 1);
        chk("empty_push_data", 32'(bus.out_data), 0);
        chk("empty_push_zero", 32'(bus.out_zero), 1);
        chk("empty_push_parity", 32'(bus.out_parity), 0);
        chk("empty_push_err", 32'(bus.out_err), 0);
        chk("empty_push_count", 32'(count), 1);
        pop();
        chk("after_pop_valid", 32'(bus.out_valid), 0);
        chk("after_pop_hold_zero", 32'(bus.out_zero), 1);

        exp_d = '{16'h0001, 16'h0003, 16'h00FF, 16'hFFFE, 16'h1234};
        exp_p = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) push(exp_d[i], 3'b001);
        chk("full_count", 32'(count), 4);
        chk("full_in_ready", 32'(bus.in_ready), 0);
        push(16'hDEAD, 3'b001);
        chk("full_reject_count", 32'(count), 4);
        chk("full_head_data", 32'(bus.out_data), 32'h0001);
        chk("full_head_parity", 32'(bus.out_parity), 1);
        pop();
        chk("full_pop_count", 32'(count), 3);
        chk("full_pop_in_ready", 32'(bus.in_ready), 1);
        push(exp_d[4], 3'b001);
        chk("wrap_count", 32'(count), 4);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("drain_data_%0d", i), 32'(bus.out_data), 32'(exp_d[i]));
            chk($sformatf("drain_parity_%0d", i), 32'(bus.out_parity), 32'(exp_p[i]));
            pop();
        end
        chk("drained_valid", 32'(bus.out_valid), 0);
        chk("drained_hold_data", 32'(bus.out_data), 32'h1234);

        bus.in_valid = 1;
        bus.out_ready = 1;
        bus.in_opcode = 3'b010;
        for (int i = 1; i <= 10; i++) begin
            bus.in_result = 16'(i);
            tick();
            chk($sformatf("stream_count_%0d", i), 32'(count), 1);
            chk($sformatf("stream_data_%0d", i), 32'(bus.out_data), 32'(i));
        end
        bus.in_valid = 0;
        tick();
        bus.out_ready = 0;
        chk("stream_end_count", 32'(count), 0);

        push(16'h0005, 3'b011);
        push(16'h0000, 3'b111);
        chk("illegal_a_err", 32'(bus.out_err), 1);
        chk("illegal_err_count", 32'(err_count), 32'(exp_err2));
        pop();
        chk("illegal_b_err", 32'(bus.out_err), 1);
        chk("illegal_b_zero", 32'(bus.out_zero), 1);
        pop();
        bus.in_valid = 1;
        bus.out_ready = 1;
        bus.in_opcode = 3'b011;
        for (int i = 0; i < 300; i++) begin
            bus.in_result = 16'(i);
            tick();
        end
        bus.in_valid = 0;
        tick();
        bus.out_ready = 0;
        chk("saturated_err_count", 32'(err_count), 32'(exp_sat));
        push(16'h00F0, 3'b100);
        chk("legal_op4_err", 32'(bus.out_err), 0);
        chk("legal_op4_parity", 32'(bus.out_parity), 0);

        push(16'h0011, 3'b000);
        push(16'h0022, 3'b000);
        chk("pre_reset_count", 32'(count), 3);
        #2 rst = 1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_in_ready", 32'(bus.in_ready), 1);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_out_data", 32'(bus.out_data), 0);
        chk("midrst_err_count", 32'(err_count), 0);
        tick();
        rst = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
